// File: rtl/fpu_sched_pkg.sv
// Shared constants, register map and FSM state type for the FPU request scheduler.
// Opcodes 6 and 7 are illegal; they are still queued so that result order is preserved.
package fpu_sched_pkg;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_MUL     = 3'd2;
  localparam logic [2:0] OP_DIV     = 3'd3;
  localparam logic [2:0] OP_INT2FLO = 3'd4;
  localparam logic [2:0] OP_FLO2INT = 3'd5;
  localparam logic [2:0] OP_ILLEGAL_MIN = 3'd6;

  localparam logic [7:0] ADDR_A      = 8'h00;
  localparam logic [7:0] ADDR_B      = 8'h01;
  localparam logic [7:0] ADDR_OP     = 8'h02;
  localparam logic [7:0] ADDR_STATUS = 8'h03;
  localparam logic [7:0] ADDR_RESULT = 8'h04;
  localparam logic [7:0] ADDR_CLEAR  = 8'h05;

  localparam int STAT_BUSY          = 0;
  localparam int STAT_CMD_FULL      = 1;
  localparam int STAT_RES_EMPTY     = 2;
  localparam int STAT_ERR           = 3;
  localparam int STAT_RES_COUNT_LSB = 4;
  localparam int STAT_CMD_COUNT_LSB = 8;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
  localparam int CMD_WIDTH = 67;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } issue_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INT2FLO, OP_FLO2INT: legal = 1'b1;
      default: legal = (op < OP_ILLEGAL_MIN);
    endcase
    return legal;
  endfunction

  // A depth-16 queue can hold 16 entries; the 4-bit status field saturates at 15.
  function automatic logic [3:0] sat_nibble(input logic [31:0] v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/fpu_sched_fifo.sv
// Synchronous FIFO with flush; used for both the command and the result queue.
// A push and pop in the same cycle is accepted even when full.
module fpu_sched_fifo
  import fpu_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_request_scheduler.sv
// Avalon-MM front end that queues FPU requests, time-shares one external core and
// returns results in issue order.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | pop head when result space exists; illegal op pushes ERR_WORD
// ST_ISSUE | fpu_start high for one cycle, latency counter loaded
// ST_WAIT  | count down; capture fpu_result on terminal count
module fpu_request_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int FPU_LATENCY = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        fpu_start,
  output logic [2:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  issue_state_t state, state_nxt;
  logic [3:0]   lat_cnt;
  logic [3:0]   lat_nxt;
  logic [31:0]  reg_a, reg_b;
  logic [2:0]   last_op;
  logic         err, set_err;
  logic         rd_pending, discard;

  logic                 cmd_full, cmd_empty, cmd_pop;
  logic [CW-1:0]        cmd_count;
  logic [CMD_WIDTH-1:0] cmd_head;
  logic                 res_full, res_empty, res_push, res_pop;
  logic [CW-1:0]        res_count;
  logic [31:0]          res_head, res_data;

  logic        wr_op_sel, op_wr, clear_wr, rd_start, rd_done;
  logic        load_issue, capture, busy;
  logic [31:0] status, rd_mux;

  assign wr_op_sel   = write && (address == ADDR_OP);
  assign op_wr       = wr_op_sel && !cmd_full;
  assign clear_wr    = write && (address == ADDR_CLEAR);
  assign waitrequest = (read && !rd_pending) || (wr_op_sel && cmd_full);
  assign rd_start    = read && !rd_pending && !((address == ADDR_RESULT) && res_empty);
  assign rd_done     = read && rd_pending;
  assign res_pop     = rd_done && (address == ADDR_RESULT);
  assign fpu_start   = (state == ST_ISSUE);
  assign lat_nxt     = lat_cnt - 4'd1;
  assign busy        = (state != ST_IDLE) || (cmd_count != '0);

  fpu_sched_fifo #(.WIDTH(CMD_WIDTH), .DEPTH(QUEUE_DEPTH)) u_cmd_q (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear_wr),
    .push      (op_wr),
    .push_data ({writedata[2:0], reg_a, reg_b}),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .count     (cmd_count),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  fpu_sched_fifo #(.WIDTH(32), .DEPTH(QUEUE_DEPTH)) u_res_q (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear_wr),
    .push      (res_push),
    .push_data (res_data),
    .pop       (res_pop),
    .pop_data  (res_head),
    .count     (res_count),
    .full      (res_full),
    .empty     (res_empty)
  );

  // Nothing is in flight while IDLE, so result space reduces to res_count alone.
  always_comb begin
    state_nxt  = state;
    cmd_pop    = 1'b0;
    res_push   = 1'b0;
    res_data   = fpu_result;
    set_err    = 1'b0;
    load_issue = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cmd_empty && (res_count < CW'(QUEUE_DEPTH))) begin
          cmd_pop = 1'b1;
          if (op_legal(cmd_head[66:64])) begin
            load_issue = 1'b1;
            state_nxt  = ST_ISSUE;
          end else begin
            res_push = 1'b1;
            res_data = ERR_WORD;
            set_err  = 1'b1;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (lat_nxt == 4'd0) begin
          capture   = 1'b1;
          res_push  = !discard;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    status = '0;
    status[STAT_BUSY]      = busy;
    status[STAT_CMD_FULL]  = cmd_full;
    status[STAT_RES_EMPTY] = res_empty;
    status[STAT_ERR]       = err;
    status[STAT_RES_COUNT_LSB +: 4] = sat_nibble(32'(res_count));
    status[STAT_CMD_COUNT_LSB +: 4] = sat_nibble(32'(cmd_count));
    case (address)
      ADDR_A:      rd_mux = reg_a;
      ADDR_B:      rd_mux = reg_b;
      ADDR_OP:     rd_mux = {29'd0, last_op};
      ADDR_STATUS: rd_mux = status;
      ADDR_RESULT: rd_mux = res_head;
      ADDR_CLEAR:  rd_mux = 32'd0;
      default:     rd_mux = ERR_WORD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      fpu_op     <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      last_op    <= '0;
      err        <= 1'b0;
      readdata   <= '0;
      rd_pending <= 1'b0;
      discard    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_issue) begin
        fpu_op <= cmd_head[66:64];
        fpu_a  <= cmd_head[63:32];
        fpu_b  <= cmd_head[31:0];
      end
      if (state == ST_ISSUE)     lat_cnt <= 4'(FPU_LATENCY);
      else if (state == ST_WAIT) lat_cnt <= lat_nxt;

      if (write && (address == ADDR_A)) reg_a <= writedata;
      if (write && (address == ADDR_B)) reg_b <= writedata;
      if (op_wr) last_op <= writedata[2:0];

      if (clear_wr)     err <= 1'b0;
      else if (set_err) err <= 1'b1;

      if (rd_start) begin
        readdata   <= rd_mux;
        rd_pending <= 1'b1;
      end else if (rd_done) begin
        rd_pending <= 1'b0;
      end

      // An op issued or in flight across a CLEAR still runs, but its result is dropped.
      if (capture)                                               discard <= 1'b0;
      else if (clear_wr && ((state != ST_IDLE) || load_issue))   discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_request_scheduler.sv
// Directed bench for fpu_request_scheduler with a fixed-latency model of the fpu core.
module tb_fpu_request_scheduler;
  localparam int L = 4;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        fpu_start;
  logic [2:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, fpu_result;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int n_start = 0;
  int start_cyc = 0;
  logic [31:0] pipe [L+1] = '{default: 32'd0};

  fpu_request_scheduler #(.FPU_LATENCY(L), .QUEUE_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .fpu_start(fpu_start), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Core model: known float pairs give real results, anything else a recognisable mix.
  function automatic logic [31:0] core_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 3'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    return {op, a[28:0] ^ b[28:0]};
  endfunction

  // Result launched at cycle s is valid throughout cycle s+L.
  always @(negedge clock) begin
    for (int i = L; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = fpu_start ? core_fn(fpu_op, fpu_a, fpu_b) : 32'd0;
    if (fpu_start) begin
      n_start++;
      start_cyc = cyc;
    end
  end
  assign fpu_result = pipe[L];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_t(input logic [7:0] a, input logic [31:0] d, output int stalls, output int acc);
    stalls = 0;
    @(negedge clock);
    address = a; writedata = d; write = 1'b1;
    #1;
    while (waitrequest && stalls < 200) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    chk("wr_timeout", {31'd0, waitrequest}, 32'd0);
    acc = cyc;
    @(posedge clock);
    #1 write = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    int s, c;
    wr_t(a, d, s, c);
  endtask

  task automatic rd_t(input logic [7:0] a, output logic [31:0] d, output int stalls);
    stalls = 0;
    @(negedge clock);
    address = a; read = 1'b1;
    #1;
    while (waitrequest && stalls < 200) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    chk("rd_timeout", {31'd0, waitrequest}, 32'd0);
    d = readdata;
    @(posedge clock);
    #1 read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int s;
    rd_t(a, d, s);
    chk(tag, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int stl, acc, s0;
    address = '0; write = 0; writedata = '0; read = 0; reset = 0;
    repeat (3) @(negedge clock);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_waitreq", {31'd0, waitrequest}, 32'd0);
    chk("rst_start", {31'd0, fpu_start}, 32'd0);
    chk("rst_op", {29'd0, fpu_op}, 32'd0);
    chk("rst_a", fpu_a, 32'd0);
    chk("rst_b", fpu_b, 32'd0);
    reset = 1;
    rd_chk("rst_status", 8'h03, 32'h4);
    rd_chk("rst_reg_a", 8'h00, 32'd0);

    // Single ADD: latency to fpu_start and to a readable result
    wr(8'h00, 32'h3F800000);
    wr(8'h01, 32'h40000000);
    s0 = n_start;
    wr_t(8'h02, 32'd0, stl, acc);
    repeat (L + 2) @(negedge clock);
    rd_t(8'h04, d, stl);
    chk("add_result", d, 32'h40400000);
    chk("add_rd_stall", 32'(stl), 32'd1);
    chk("start_latency", 32'(start_cyc - acc), 32'd2);
    chk("add_starts", 32'(n_start - s0), 32'd1);
    rd_chk("add_status", 8'h03, 32'h4);

    // Six back-to-back OPs: the sixth stalls while the queue is full
    wr(8'h00, 32'h12345678);
    wr(8'h01, 32'h0F0F0F0F);
    for (int i = 0; i < 6; i++) begin
      wr_t(8'h02, 32'(i), stl, acc);
      chk($sformatf("burst_stall%0d", i), 32'(stl), (i == 5) ? 32'd3 : 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      rd_t(8'h04, d, stl);
      chk($sformatf("burst_res%0d", i), d, core_fn(3'(i), 32'h12345678, 32'h0F0F0F0F));
    end

    // RESULT read on an empty queue waits for the MUL capture
    wr(8'h00, 32'h40000000);
    wr(8'h01, 32'h40400000);
    wr(8'h02, 32'd2);
    rd_t(8'h04, d, stl);
    chk("mul_result", d, 32'h40C00000);
    chk("mul_rd_stall", 32'(stl), 32'(L + 3));

    // Illegal op between two ADDs
    wr(8'h00, 32'h3F800000);
    wr(8'h01, 32'h40000000);
    s0 = n_start;
    wr(8'h02, 32'd0);
    wr(8'h02, 32'd7);
    wr(8'h02, 32'd0);
    rd_chk("ill_res0", 8'h04, 32'h40400000);
    rd_chk("ill_res1", 8'h04, 32'hDEADBEEF);
    rd_chk("ill_res2", 8'h04, 32'h40400000);
    chk("ill_starts", 32'(n_start - s0), 32'd2);
    rd_chk("ill_status", 8'h03, 32'hC);
    rd_chk("ill_last_op", 8'h02, 32'd0);
    wr(8'h05, 32'd1);
    rd_chk("clr_status", 8'h03, 32'h4);

    // CLEAR right behind an OP: the op still runs but its result is dropped
    wr(8'h02, 32'd0);
    wr(8'h05, 32'd1);
    repeat (10) @(negedge clock);
    rd_chk("clr_discard", 8'h03, 32'h4);
    rd_chk("clr_keeps_a", 8'h00, 32'h3F800000);

    // Reset while WAIT is counting
    wr(8'h00, 32'h11111111);
    wr(8'h01, 32'h22222222);
    rd_chk("pre_rst_status", 8'h03, 32'h4);
    wr(8'h02, 32'd2);
    repeat (3) @(negedge clock);
    reset = 0;
    #1;
    chk("mid_rst_start", {31'd0, fpu_start}, 32'd0);
    chk("mid_rst_op", {29'd0, fpu_op}, 32'd0);
    chk("mid_rst_a", fpu_a, 32'd0);
    chk("mid_rst_b", fpu_b, 32'd0);
    chk("mid_rst_readdata", readdata, 32'd0);
    chk("mid_rst_waitreq", {31'd0, waitrequest}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1;
    repeat (L + 4) @(negedge clock);
    rd_chk("post_rst_status", 8'h03, 32'h4);
    rd_chk("post_rst_a", 8'h00, 32'd0);

    // Unmapped address
    wr(8'h00, 32'hCAFEF00D);
    wr(8'h20, 32'h12345678);
    rd_t(8'h20, d, stl);
    chk("bad_addr_data", d, 32'hDEADBEEF);
    chk("bad_addr_stall", 32'(stl), 32'd1);
    rd_chk("bad_wr_a", 8'h00, 32'hCAFEF00D);
    rd_chk("bad_wr_b", 8'h01, 32'd0);
    rd_chk("bad_wr_status", 8'h03, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
